// File: rtl/sramlike_pkg.sv
// Shared definitions for the data-side sram-like responder: size codes,
// byte-enable constants and the response-queue entry layout.
package sramlike_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0] WSTRB_NONE = 4'b0000;

    // Wide enough for any practical response delay.
    localparam int TIMER_W = 8;

    typedef struct packed {
        logic               wr;
        logic [TIMER_W-1:0] timer;
        logic [31:0]        rdata;
        logic               captured;
    } resp_entry_t;

endpackage

// File: rtl/sramlike_resp_queue.sv
// In-order response queue: circular buffer of outstanding requests with
// per-entry countdown timers and a one-cycle-late read-data capture port.
module sramlike_resp_queue
    import sramlike_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int RESP_DELAY = 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          push_wr,
    input  logic [31:0]   cap_data,
    output logic          retire,
    output resp_entry_t   head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_entry_t      entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    head_ptr;
    logic [PW-1:0]    tail_ptr;
    logic             cap_pending;
    logic [PW-1:0]    cap_idx;

    assign head   = entries[head_ptr];
    assign retire = valid[head_ptr] && (entries[head_ptr].timer == '0);

    // Later assignments win: capture, then pop, then push, so a slot that is
    // retired and refilled in the same cycle ends up holding the new request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid       <= '0;
            head_ptr    <= '0;
            tail_ptr    <= '0;
            count       <= '0;
            cap_pending <= 1'b0;
            cap_idx     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i] && entries[i].timer != '0) begin
                    entries[i].timer <= entries[i].timer - TIMER_W'(1);
                end
            end
            if (cap_pending) begin
                entries[cap_idx].rdata    <= cap_data;
                entries[cap_idx].captured <= 1'b1;
            end
            if (retire) begin
                valid[head_ptr] <= 1'b0;
                head_ptr        <= (head_ptr == PW'(DEPTH - 1)) ? '0 : head_ptr + PW'(1);
            end
            if (push) begin
                // Writes are answered with zero data, so they start out captured.
                entries[tail_ptr] <= '{wr: push_wr, timer: TIMER_W'(RESP_DELAY - 1),
                                       rdata: 32'h0, captured: push_wr};
                valid[tail_ptr]   <= 1'b1;
                tail_ptr          <= (tail_ptr == PW'(DEPTH - 1)) ? '0 : tail_ptr + PW'(1);
            end
            cap_pending <= push && !push_wr;
            cap_idx     <= tail_ptr;
            case ({push, retire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_sramlike_slave.sv
// Responder end of the data-side sram-like bus: issues each accepted request
// straight to a 1-cycle-latency SRAM and answers in order after a fixed delay.
module data_sramlike_slave
    import sramlike_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int RESP_DELAY = 1,
    parameter int SRAM_AW    = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               data_sram_req,
    input  logic               data_sram_wr,
    input  logic [1:0]         data_sram_size,
    input  logic [31:0]        data_sram_addr,
    input  logic [3:0]         data_sram_wstrb,
    input  logic [31:0]        data_sram_wdata,
    output logic               data_sram_addrok,
    output logic               data_sram_dataok,
    output logic [31:0]        data_sram_rdata,
    output logic               sram_en,
    output logic [3:0]         sram_wen,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count;
    logic          retire;
    resp_entry_t   head;
    logic          handshake;
    logic          unused_bits;

    sramlike_resp_queue #(
        .DEPTH      (DEPTH),
        .RESP_DELAY (RESP_DELAY)
    ) u_queue (
        .clk      (clk),
        .resetn   (resetn),
        .push     (handshake),
        .push_wr  (data_sram_wr),
        .cap_data (sram_rdata),
        .retire   (retire),
        .head     (head),
        .count    (count)
    );

    // Acceptance looks only at queue state; a retiring head frees its slot.
    assign data_sram_addrok = (count < CW'(DEPTH)) || retire;
    assign handshake        = data_sram_req && data_sram_addrok;

    assign sram_en    = handshake;
    assign sram_wen   = (handshake && data_sram_wr) ? data_sram_wstrb : WSTRB_NONE;
    assign sram_addr  = handshake ? data_sram_addr[SRAM_AW+1:2] : '0;
    assign sram_wdata = handshake ? data_sram_wdata : 32'h0;

    // An uncaptured head is a read accepted last cycle; its data is on the SRAM port now.
    assign data_sram_dataok = retire;
    assign data_sram_rdata  = !retire      ? 32'h0 :
                              head.captured ? head.rdata : sram_rdata;

    assign unused_bits = (data_sram_size == SZ_BYTE) ^ (data_sram_size == SZ_HALF) ^
                         (data_sram_size == SZ_WORD) ^ head.wr ^
                         (^data_sram_addr[31:SRAM_AW+2]) ^ (^data_sram_addr[1:0]);

endmodule

// File: tb/tb_data_sramlike_slave.sv
// Self-checking bench: three responders (RESP_DELAY 1, 3, 4) each backed by a
// small behavioural SRAM; directed vector table plus multi-cycle sequences.
module tb_data_sramlike_slave;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        req    [3];
    logic        wr     [3];
    logic [1:0]  size   [3];
    logic [31:0] addr   [3];
    logic [3:0]  wstrb  [3];
    logic [31:0] wdata  [3];
    logic        addrok [3];
    logic        dataok [3];
    logic [31:0] rdata  [3];
    logic        en     [3];
    logic [3:0]  wen    [3];
    logic [15:0] saddr  [3];
    logic [31:0] swdata [3];
    logic [31:0] srdata [3];

    logic [31:0] mem [3][256];
    logic        mem_loaded = 1'b0;

    int tests = 0;
    int fails = 0;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            data_sramlike_slave #(
                .DEPTH      (2),
                .RESP_DELAY ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
                .SRAM_AW    (16)
            ) dut (
                .clk              (clk),
                .resetn           (resetn),
                .data_sram_req    (req[g]),
                .data_sram_wr     (wr[g]),
                .data_sram_size   (size[g]),
                .data_sram_addr   (addr[g]),
                .data_sram_wstrb  (wstrb[g]),
                .data_sram_wdata  (wdata[g]),
                .data_sram_addrok (addrok[g]),
                .data_sram_dataok (dataok[g]),
                .data_sram_rdata  (rdata[g]),
                .sram_en          (en[g]),
                .sram_wen         (wen[g]),
                .sram_addr        (saddr[g]),
                .sram_wdata       (swdata[g]),
                .sram_rdata       (srdata[g])
            );
        end
    endgenerate

    function automatic logic [31:0] init_word(int k, int idx);
        logic [31:0] w40 [3];
        logic [31:0] w41 [3];
        logic [31:0] w42 [3];
        w40 = '{32'hDEADBEEF, 32'hA0000000, 32'hB0B0B0B0};
        w41 = '{32'hCAFEF00D, 32'hA1000000, 32'hB1B1B1B1};
        w42 = '{32'h01234567, 32'hA2000000, 32'hB2B2B2B2};
        case (idx)
            8'h40:   return w40[k];
            8'h41:   return w41[k];
            8'h42:   return w42[k];
            default: return 32'h0;
        endcase
    endfunction

    // Behavioural SRAM: one-cycle read latency, byte-masked writes.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 256; i++) begin
                    mem[k][i] <= init_word(k, i);
                end
                srdata[k] <= 32'h0;
            end
            mem_loaded <= 1'b1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (en[k]) begin
                    if (wen[k] == 4'b0000) begin
                        srdata[k] <= mem[k][saddr[k][7:0]];
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (wen[k][b]) mem[k][saddr[k][7:0]][b*8 +: 8] <= swdata[k][b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    task automatic apply_stimulus(int k, logic rq, logic w, logic [31:0] a,
                                  logic [3:0] s, logic [31:0] d);
        @(negedge clk);
        req[k]   = rq;
        wr[k]    = w;
        addr[k]  = a;
        wstrb[k] = s;
        wdata[k] = d;
        size[k]  = 2'd2;
        #1;
    endtask

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rq;
        logic        w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        e_addrok;
        logic        e_en;
        logic [3:0]  e_wen;
        logic [15:0] e_saddr;
        logic [31:0] e_swdata;
        logic        e_dataok;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] exp_q [$];
    logic [31:0] exp_val;
    int          n_resp;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, limit 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Instance 0 (RESP_DELAY=1): one row per cycle.
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 4'h0, 16'h0000, 32'h0,        1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h100,      4'h0, 32'h0,        1'b1, 1'b1, 4'h0, 16'h0040, 32'h0,        1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 4'h0, 16'h0000, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b1, 32'h100,      4'hF, 32'h11223344, 1'b1, 1'b1, 4'hF, 16'h0040, 32'h11223344, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 32'h103,      4'h8, 32'h5A5A5A5A, 1'b1, 1'b1, 4'h8, 16'h0040, 32'h5A5A5A5A, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h100,      4'h0, 32'h0,        1'b1, 1'b1, 4'h0, 16'h0040, 32'h0,        1'b1, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 4'h0, 16'h0000, 32'h0,        1'b1, 32'h5A223344};
        vecs[7]  = '{1'b1, 1'b0, 32'h104,      4'h0, 32'h0,        1'b1, 1'b1, 4'h0, 16'h0041, 32'h0,        1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h108,      4'h0, 32'h0,        1'b1, 1'b1, 4'h0, 16'h0042, 32'h0,        1'b1, 32'hCAFEF00D};
        vecs[9]  = '{1'b1, 1'b0, 32'hFFFF0100, 4'h0, 32'h0,        1'b1, 1'b1, 4'h0, 16'hC040, 32'h0,        1'b1, 32'h01234567};
        vecs[10] = '{1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 4'h0, 16'h0000, 32'h0,        1'b1, 32'h5A223344};
        vecs[11] = '{1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 4'h0, 16'h0000, 32'h0,        1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 32'h100,      4'hF, 32'hFFFFFFFF, 1'b1, 1'b1, 4'h0, 16'h0040, 32'hFFFFFFFF, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 4'h0, 16'h0000, 32'h0,        1'b1, 32'h5A223344};

        resetn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; wr[k] = 1'b0; size[k] = 2'd0;
            addr[k] = 32'h0; wstrb[k] = 4'h0; wdata[k] = 32'h0;
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Reset values on every instance.
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(k, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            check_output($sformatf("reset%0d addrok", k), 32'(addrok[k]), 32'h1);
            check_output($sformatf("reset%0d dataok", k), 32'(dataok[k]), 32'h0);
            check_output($sformatf("reset%0d rdata", k), rdata[k], 32'h0);
            check_output($sformatf("reset%0d sram_en", k), 32'(en[k]), 32'h0);
        end

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(0, vecs[i].rq, vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d);
            check_output($sformatf("vec%0d addrok", i), 32'(addrok[0]), 32'(vecs[i].e_addrok));
            check_output($sformatf("vec%0d sram_en", i), 32'(en[0]), 32'(vecs[i].e_en));
            check_output($sformatf("vec%0d sram_wen", i), 32'(wen[0]), 32'(vecs[i].e_wen));
            check_output($sformatf("vec%0d sram_addr", i), 32'(saddr[0]), 32'(vecs[i].e_saddr));
            check_output($sformatf("vec%0d sram_wdata", i), swdata[0], vecs[i].e_swdata);
            check_output($sformatf("vec%0d dataok", i), 32'(dataok[0]), 32'(vecs[i].e_dataok));
            check_output($sformatf("vec%0d rdata", i), rdata[0], vecs[i].e_rdata);
        end

        // Instance 1 (RESP_DELAY=3): fill, stall, then accept on full+retire.
        apply_stimulus(1, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
        check_output("fill n0 addrok", 32'(addrok[1]), 32'h1);
        check_output("fill n0 sram_en", 32'(en[1]), 32'h1);
        apply_stimulus(1, 1'b1, 1'b0, 32'h104, 4'h0, 32'h0);
        check_output("fill n1 addrok", 32'(addrok[1]), 32'h1);
        check_output("fill n1 dataok", 32'(dataok[1]), 32'h0);
        apply_stimulus(1, 1'b1, 1'b0, 32'h108, 4'h0, 32'h0);
        check_output("fill n2 addrok", 32'(addrok[1]), 32'h0);
        check_output("fill n2 sram_en", 32'(en[1]), 32'h0);
        check_output("fill n2 dataok", 32'(dataok[1]), 32'h0);
        apply_stimulus(1, 1'b1, 1'b0, 32'h108, 4'h0, 32'h0);
        check_output("fill n3 addrok", 32'(addrok[1]), 32'h1);
        check_output("fill n3 sram_en", 32'(en[1]), 32'h1);
        check_output("fill n3 sram_addr", 32'(saddr[1]), 32'h42);
        check_output("fill n3 dataok", 32'(dataok[1]), 32'h1);
        check_output("fill n3 rdata", rdata[1], 32'hA0000000);
        apply_stimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check_output("fill n4 dataok", 32'(dataok[1]), 32'h1);
        check_output("fill n4 rdata", rdata[1], 32'hA1000000);
        apply_stimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check_output("fill n5 dataok", 32'(dataok[1]), 32'h0);
        apply_stimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check_output("fill n6 dataok", 32'(dataok[1]), 32'h1);
        check_output("fill n6 rdata", rdata[1], 32'hA2000000);
        apply_stimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check_output("fill n7 dataok", 32'(dataok[1]), 32'h0);

        // Instance 0: alternating write/read pairs wrap the pointers repeatedly.
        n_resp = 0;
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            for (int ph = 0; ph < 2; ph++) begin
                apply_stimulus(0, 1'b1, (ph == 0), 32'h200 + 32'(4 * i), 4'hF,
                               (ph == 0) ? (32'h10000000 + 32'(i) * 32'h01010101) : 32'h0);
                if (dataok[0]) begin
                    n_resp++;
                    exp_val = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
                    check_output($sformatf("wrap resp%0d rdata", n_resp), rdata[0], exp_val);
                end
                check_output($sformatf("wrap pair%0d.%0d addrok", i, ph), 32'(addrok[0]), 32'h1);
                if (addrok[0]) exp_q.push_back((ph == 0) ? 32'h0 : 32'h10000000 + 32'(i) * 32'h01010101);
            end
        end
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            if (dataok[0]) begin
                n_resp++;
                exp_val = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
                check_output($sformatf("wrap resp%0d rdata", n_resp), rdata[0], exp_val);
            end
        end
        check_output("wrap dataok count", 32'(n_resp), 32'd20);

        // Instance 2 (RESP_DELAY=4): reset with two reads in flight.
        apply_stimulus(2, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
        check_output("rst n0 addrok", 32'(addrok[2]), 32'h1);
        apply_stimulus(2, 1'b1, 1'b0, 32'h104, 4'h0, 32'h0);
        check_output("rst n1 addrok", 32'(addrok[2]), 32'h1);
        apply_stimulus(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check_output("rst n2 full addrok", 32'(addrok[2]), 32'h0);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_output("rst asserted addrok", 32'(addrok[2]), 32'h1);
        check_output("rst asserted dataok", 32'(dataok[2]), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            apply_stimulus(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            check_output($sformatf("rst after%0d dataok", c), 32'(dataok[2]), 32'h0);
            check_output($sformatf("rst after%0d addrok", c), 32'(addrok[2]), 32'h1);
        end
        apply_stimulus(2, 1'b1, 1'b0, 32'h104, 4'h0, 32'h0);
        check_output("rst fresh sram_en", 32'(en[2]), 32'h1);
        for (int j = 1; j <= 5; j++) begin
            apply_stimulus(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            check_output($sformatf("rst fresh +%0d dataok", j), 32'(dataok[2]), (j == 4) ? 32'h1 : 32'h0);
            if (j == 4) check_output("rst fresh rdata", rdata[2], 32'hB1B1B1B1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
